// File: rtl/bram_stream_loader.sv
// Turns a valid/ready word stream into sequential BRAM port-A writes and flags load completion.
// Optional `BRAM_LOADER_CHECKSUM_EN adds a 32-bit running sum of accepted words.
module bram_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 500,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_words,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_W-1:0]     bram_addra,
    output logic                  load_done,
    output logic                  busy,
`ifdef BRAM_LOADER_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  err
);

    // Stream handshake: a word transfers on every rising edge where s_valid && s_ready.
    // s_ready is high only in LOAD and does not depend on s_valid.
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, num_lat, cnt_inc;
    logic              start_in, start_zero, start_big, start_go;
    logic              accept, final_beat, end_beat;

    assign start_in   = start && (state != LOAD);
    assign start_zero = start_in && (num_words == '0);
    assign start_big  = start_in && (num_words > CNT_W'(DEPTH));
    assign start_go   = start_in && !start_zero && !start_big;
    assign accept     = s_valid && s_ready;
    assign cnt_inc    = cnt + CNT_W'(1);
    assign final_beat = accept && (cnt_inc == num_lat);
    assign end_beat   = accept && (final_beat || s_last);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_go)        state_nxt = LOAD;
                else if (start_zero) state_nxt = DONE;
            end
            LOAD: begin
                if (end_beat) state_nxt = DONE;
            end
            DONE: begin
                if (start_go)        state_nxt = LOAD;
                else if (start_zero) state_nxt = DONE;
                else if (start_big)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state == LOAD);
    end

    // Write strobe lags acceptance by one cycle; load_done lags the DONE entry by one more.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            num_lat    <= '0;
            bram_din   <= '0;
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            bram_ena <= accept;
            bram_wea <= accept;
            if (accept) begin
                bram_din   <= s_data;
                bram_addra <= cnt[ADDR_W-1:0];
                cnt        <= cnt_inc;
            end
            if (start_go) begin
                num_lat   <= num_words;
                cnt       <= '0;
                err       <= 1'b0;
                load_done <= 1'b0;
            end else if (start_zero) begin
                num_lat   <= '0;
                cnt       <= '0;
                err       <= 1'b0;
                load_done <= 1'b1;
            end else if (start_big) begin
                err       <= 1'b1;
                load_done <= 1'b0;
            end else begin
                if (state == DONE) load_done <= 1'b1;
                // Early s_last and a final beat lacking s_last are both length errors.
                if (accept && (s_last != final_beat)) err <= 1'b1;
            end
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)                      checksum <= '0;
        else if (start_go || start_zero) checksum <= '0;
        else if (accept)              checksum <= checksum + 32'(s_data);
    end
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Randomized bench for bram_stream_loader: planned loads predict the write list and completion flags.
module tb_bram_stream_loader;
    localparam int DW    = 8;
    localparam int DEPTH = 20;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_words;
    logic [DW-1:0] s_data;
    logic          s_valid, s_last, s_ready;
    logic [DW-1:0] bram_din;
    logic          bram_ena, bram_wea;
    logic [AW-1:0] bram_addra;
    logic          load_done, busy, err;
`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    bram_stream_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .bram_din(bram_din), .bram_ena(bram_ena), .bram_wea(bram_wea),
        .bram_addra(bram_addra), .load_done(load_done), .busy(busy),
`ifdef BRAM_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_strobe(input bit exp_ena);
        logic [AW+DW-1:0] e;
        check("ena", 32'(bram_ena), 32'(exp_ena));
        check("wea", 32'(bram_wea), 32'(exp_ena));
        if (exp_ena && bram_ena) begin
            check("q_size_nonzero", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("addra", 32'(bram_addra), 32'(e[AW+DW-1:DW]));
                check("din", 32'(bram_din), 32'(e[DW-1:0]));
            end
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between beats, 2 random idles.
    // last_pos: beat index carrying s_last; out of range means s_last is never sent.
    task automatic do_load(input int n, input int last_pos, input int gap_mode, input bit fixed);
        int            end_n;
        bit            exp_err, prev, gap;
        logic [DW-1:0] d;
        logic [31:0]   sum;
        start = 1'b1;
        num_words = CW'(n);
        step();
        start = 1'b0;
        if (n > DEPTH) begin
            check("big_err", 32'(err), 32'd1);
            check("big_done", 32'(load_done), 32'd0);
            check("big_busy", 32'(busy), 32'd0);
            s_valid = 1'b1;
            s_data = DW'($urandom);
            step();
            check("big_ready", 32'(s_ready), 32'd0);
            check_strobe(1'b0);
            s_valid = 1'b0;
            step();
            check_strobe(1'b0);
            check("big_err_hold", 32'(err), 32'd1);
            return;
        end
        if (n == 0) begin
            check("zero_done", 32'(load_done), 32'd1);
            check("zero_err", 32'(err), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
            check_strobe(1'b0);
`ifdef BRAM_LOADER_CHECKSUM_EN
            check("zero_sum", checksum, 32'd0);
`endif
            return;
        end
        check("go_done_low", 32'(load_done), 32'd0);
        check("go_busy", 32'(busy), 32'd1);
        end_n = (last_pos >= 0 && last_pos < n) ? last_pos + 1 : n;
        exp_err = (last_pos != n - 1);
        prev = 1'b0;
        sum = '0;
        for (int i = 0; i < end_n; i++) begin
            gap = (gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            if (gap) begin
                check("gap_ready", 32'(s_ready), 32'd1);
                check_strobe(prev);
                s_valid = 1'b0;
                s_data = DW'($urandom);
                s_last = 1'($urandom);
                step();
                prev = 1'b0;
            end
            check("beat_ready", 32'(s_ready), 32'd1);
            check("beat_done_low", 32'(load_done), 32'd0);
            check_strobe(prev);
            d = fixed ? DW'((i + 1) * 17) : DW'($urandom);
            s_valid = 1'b1;
            s_data = d;
            s_last = (i == last_pos);
            exp_q.push_back({AW'(i), d});
            sum += 32'(d);
            step();
            prev = 1'b1;
        end
        check_strobe(1'b1);
        check("end_ready", 32'(s_ready), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done_early", 32'(load_done), 32'd0);
        s_valid = 1'b1;
        s_last = 1'b0;
        s_data = DW'($urandom);
        step();
        check_strobe(1'b0);
        check("done", 32'(load_done), 32'd1);
        check("err", 32'(err), 32'(exp_err));
        check("q_drain", 32'(exp_q.size()), 32'd0);
`ifdef BRAM_LOADER_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
        s_valid = 1'b0;
        step();
        check_strobe(1'b0);
        check("done_hold", 32'(load_done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"}, 32'(bram_ena), 32'd0);
        check({tag, "_wea"}, 32'(bram_wea), 32'd0);
        check({tag, "_din"}, 32'(bram_din), 32'd0);
        check({tag, "_addra"}, 32'(bram_addra), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int n, lp, r;
        rst = 1'b1;
        start = 1'b0;
        num_words = '0;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check("idle_ready", 32'(s_ready), 32'd0);

        do_load(4, 3, 0, 1'b1);
        do_load(3, 2, 1, 1'b0);
        do_load(5, 1, 0, 1'b0);
        do_load(0, -1, 0, 1'b0);
        do_load(DEPTH + 1, -1, 0, 1'b0);
        do_load(DEPTH, DEPTH - 1, 2, 1'b0);

        // Abandon a load after three beats.
        start = 1'b1;
        num_words = CW'(8);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_strobe(i > 0);
            s_valid = 1'b1;
            s_data = DW'($urandom);
            s_last = 1'b0;
            exp_q.push_back({AW'(i), s_data});
            step();
        end
        check_strobe(1'b1);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        step();
        check_strobe(1'b0);
        do_load(2, 1, 0, 1'b0);
        do_load(1, 0, 0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, DEPTH + 1);
            r = $urandom_range(0, 3);
            if (r == 1 && n > 0) lp = $urandom_range(0, n - 1);
            else if (r == 2)     lp = -1;
            else                 lp = n - 1;
            do_load(n, lp, $urandom_range(0, 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
